mmio_axil_master: RTL and testbench

//  CPU-side bridge directly upstream of mmio_subsystem: turns single load/store requests

---
 rtl/mmio_axil_master.sv | 176 +++++++++++++++++
 tb/tb_mmio_axil_master.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_axil_master.sv
// CPU load/store to AXI4-Lite master bridge, one transaction in flight, with response watchdog.
// Latency: accept@N, AXI valid@N+1, rsp_valid one cycle after B/R handshake; stalls on slave/CPU ready.
module mmio_axil_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  arst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_W-1:0]     M_AXI_awaddr,
    output logic [2:0]            M_AXI_awprot,
    output logic                  M_AXI_awvalid,
    input  logic                  M_AXI_awready,
    output logic [DATA_W-1:0]     M_AXI_wdata,
    output logic [DATA_W/8-1:0]   M_AXI_wstrb,
    output logic                  M_AXI_wvalid,
    input  logic                  M_AXI_wready,
    input  logic [1:0]            M_AXI_bresp,
    input  logic                  M_AXI_bvalid,
    output logic                  M_AXI_bready,
    output logic [ADDR_W-1:0]     M_AXI_araddr,
    output logic [2:0]            M_AXI_arprot,
    output logic                  M_AXI_arvalid,
    input  logic                  M_AXI_arready,
    input  logic [DATA_W-1:0]     M_AXI_rdata,
    input  logic [1:0]            M_AXI_rresp,
    input  logic                  M_AXI_rvalid,
    output logic                  M_AXI_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic                aw_done, w_done;
    logic [CNT_W-1:0]    wdog_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;

    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, busy, expire;

    assign accept = req_valid && req_ready;
    assign aw_hs  = M_AXI_awvalid && M_AXI_awready;
    assign w_hs   = M_AXI_wvalid  && M_AXI_wready;
    assign b_hs   = M_AXI_bvalid  && M_AXI_bready;
    assign ar_hs  = M_AXI_arvalid && M_AXI_arready;
    assign r_hs   = M_AXI_rvalid  && M_AXI_rready;
    assign busy   = (state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
    assign expire = busy && (wdog_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A B/R handshake beats a simultaneous watchdog expiry; address-phase handshakes do not.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = req_we ? WADDR : RADDR;
            WADDR: begin
                if (expire)
                    state_nxt = RESP;
                else if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nxt = WRESP;
            end
            WRESP: if (b_hs || expire) state_nxt = RESP;
            RADDR: begin
                if (expire)
                    state_nxt = RESP;
                else if (ar_hs)
                    state_nxt = RDATA;
            end
            RDATA: if (r_hs || expire) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_awvalid = 1'b0;
        M_AXI_wvalid  = 1'b0;
        M_AXI_bready  = 1'b0;
        M_AXI_arvalid = 1'b0;
        M_AXI_rready  = 1'b0;
        case (state)
            IDLE:  req_ready = 1'b1;
            WADDR: begin
                M_AXI_awvalid = !aw_done;
                M_AXI_wvalid  = !w_done;
            end
            WRESP: M_AXI_bready  = 1'b1;
            RADDR: M_AXI_arvalid = 1'b1;
            RDATA: M_AXI_rready  = 1'b1;
            RESP:  rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wdog_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            resp_q   <= 2'b00;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                wstrb_q  <= req_wstrb;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                wdog_cnt <= '0;
            end else if (busy) begin
                wdog_cnt <= wdog_cnt + CNT_W'(1);
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;

            if (state == WRESP && b_hs) begin
                resp_q  <= M_AXI_bresp;
                rdata_q <= '0;
            end else if (state == RDATA && r_hs) begin
                resp_q  <= M_AXI_rresp;
                rdata_q <= M_AXI_rdata;
            end else if (expire) begin
                resp_q  <= 2'b11;
                rdata_q <= '0;
            end
        end
    end

    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign M_AXI_awaddr = addr_q;
    assign M_AXI_araddr = addr_q;
    assign M_AXI_wdata  = wdata_q;
    assign M_AXI_wstrb  = wstrb_q;
    assign M_AXI_awprot = 3'b000;
    assign M_AXI_arprot = 3'b000;

endmodule

// File: tb/tb_mmio_axil_master.sv
// Directed bench for mmio_axil_master: table of transactions against a delay-programmable slave.
module tb_mmio_axil_master;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_axil_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
        .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;   // cycles of bready/rready before the slave answers
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        int          hold;      // cycles the CPU stalls the response
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;   // cycle index (1 = first cycle after accept) of rsp_valid
        int          exp_aw;
        int          exp_w;
        int          exp_ar;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int c = 1, aw_n = 0, w_n = 0, ar_n = 0, br_n = 0, rr_n = 0, lat = 0, stab_err = 0;
        bit done = 0;
        @(negedge clk);
        chk({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        @(negedge clk);
        req_valid = 0; req_addr = 8'h00; req_wdata = 32'h0; req_wstrb = 4'h0;
        while (!done && c < 200) begin
            if (rsp_valid) begin
                lat = c;
                done = 1;
                slave_idle();
            end else begin
                if (awvalid) begin
                    aw_n++;
                    if (awaddr !== v.addr || awprot !== 3'b000) stab_err++;
                end
                if (wvalid) begin
                    w_n++;
                    if (wdata !== v.wdata || wstrb !== v.wstrb) stab_err++;
                end
                if (arvalid) begin
                    ar_n++;
                    if (araddr !== v.addr || arprot !== 3'b000) stab_err++;
                end
                awready = awvalid && (aw_n > v.aw_dly);
                wready  = wvalid  && (w_n  > v.w_dly);
                arready = arvalid && (ar_n > v.ar_dly);
                if (bready) br_n++;
                bvalid = bready && (br_n > v.rsp_dly);
                bresp  = v.s_resp;
                if (rready) rr_n++;
                rvalid = rready && (rr_n > v.rsp_dly);
                rdata  = v.s_rdata;
                rresp  = v.s_resp;
                @(negedge clk);
                c++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s.no_response: got none expected rsp_valid by cycle %0d", nm, v.exp_lat);
            slave_idle();
            arst_n = 0; @(negedge clk); arst_n = 1;
        end else begin
            chk({nm, ".latency"},   32'(lat),  32'(v.exp_lat));
            chk({nm, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
            chk({nm, ".rsp_resp"},  32'(rsp_resp), 32'(v.exp_resp));
            chk({nm, ".aw_cycles"}, 32'(aw_n), 32'(v.exp_aw));
            chk({nm, ".w_cycles"},  32'(w_n),  32'(v.exp_w));
            chk({nm, ".ar_cycles"}, 32'(ar_n), 32'(v.exp_ar));
            chk({nm, ".chan_stable"}, 32'(stab_err), 32'd0);
            chk({nm, ".req_ready_resp"}, 32'(req_ready), 32'd0);
            // CPU keeps offering a new load while stalling the response
            for (int h = 0; h < v.hold; h++) begin
                req_valid = 1; req_we = 0; req_addr = 8'h33;
                @(negedge clk);
                chk({nm, ".hold_rsp_valid"}, 32'(rsp_valid), 32'd1);
                chk({nm, ".hold_rdata"}, rsp_rdata, v.exp_rdata);
                chk({nm, ".hold_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
                chk({nm, ".hold_req_ready"}, 32'(req_ready), 32'd0);
                chk({nm, ".hold_no_axi"}, 32'(awvalid | wvalid | arvalid), 32'd0);
            end
            req_valid = 0;
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            chk({nm, ".rsp_consumed"}, 32'(rsp_valid), 32'd0);
            chk({nm, ".back_idle"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int rsp_seen;
        arst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        rsp_ready = 0;
        slave_idle();

        //        we  addr   wdata         strb aw w  ar    rsp   s_rdata       s_resp hold exp_rdata     exp_resp lat aw w  ar
        vecs[0] = '{1'b1, 8'h01, 32'd200,      4'hF, 0, 0, 0,    0,    32'h0,        2'b00, 0, 32'h0,        2'b00, 3,  1, 1, 0};
        vecs[1] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'h5, 3, 0, 0,    0,    32'h0,        2'b00, 0, 32'h0,        2'b00, 6,  4, 1, 0};
        vecs[2] = '{1'b0, 8'h01, 32'h0,        4'h0, 0, 0, 0,    2,    32'd200,      2'b00, 0, 32'd200,      2'b00, 5,  0, 0, 1};
        vecs[3] = '{1'b0, 8'hFF, 32'h0,        4'h0, 0, 0, 0,    0,    32'h12345678, 2'b11, 5, 32'h12345678, 2'b11, 3,  0, 0, 1};
        vecs[4] = '{1'b1, 8'h20, 32'hCAFE0001, 4'h3, 0, 2, 0,    0,    32'h0,        2'b10, 0, 32'h0,        2'b10, 5,  1, 3, 0};
        vecs[5] = '{1'b1, 8'h24, 32'h01020304, 4'h8, 2, 2, 0,    0,    32'h0,        2'b00, 0, 32'h0,        2'b00, 5,  3, 3, 0};
        vecs[6] = '{1'b0, 8'h30, 32'h0,        4'h0, 0, 0, 1000, 0,    32'hFFFFFFFF, 2'b00, 0, 32'h0,        2'b11, 65, 0, 0, 64};
        vecs[7] = '{1'b0, 8'h04, 32'h0,        4'h0, 0, 0, 0,    0,    32'hA5A5A5A5, 2'b00, 0, 32'hA5A5A5A5, 2'b00, 3,  0, 0, 1};
        vecs[8] = '{1'b1, 8'h08, 32'h55AA55AA, 4'hF, 0, 0, 0,    1000, 32'h0,        2'b00, 0, 32'h0,        2'b11, 65, 1, 1, 0};
        vecs[9] = '{1'b0, 8'h0C, 32'h0,        4'h0, 0, 0, 0,    1,    32'h0BADF00D, 2'b10, 0, 32'h0BADF00D, 2'b10, 4,  0, 0, 1};

        repeat (3) @(negedge clk);
        chk("reset.valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'h0);
        chk("reset.rsp_resp", 32'(rsp_resp), 32'd0);
        arst_n = 1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for B: transaction abandoned, no response afterwards
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 8'h40; req_wdata = 32'h77; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 0;
        awready = awvalid; wready = wvalid;
        @(negedge clk);
        awready = 0; wready = 0;
        chk("midreset.in_wresp", 32'(bready), 32'd1);
        arst_n = 0;
        @(negedge clk);
        chk("midreset.valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        chk("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset.rsp_rdata", rsp_rdata, 32'h0);
        chk("midreset.rsp_resp", 32'(rsp_resp), 32'd0);
        arst_n = 1;
        rsp_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("midreset.no_rsp", 32'(rsp_seen), 32'd0);
        run_vec(vecs[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
